// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT stream framer: state encoding and default widths.
package fft_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StPad
    } framer_state_e;

    localparam int unsigned DefDataW  = 18;
    localparam int unsigned DefPtsW   = 11;
    localparam int unsigned DefMaxPts = 1024;
    localparam int unsigned DefMinPts = 8;

endpackage

// File: rtl/fft_stream_outreg.sv
// Single-entry output register toward the FFT sink; holds its beat while the sink stalls.
module fft_stream_outreg
    import fft_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * DefDataW + DefPtsW + 1
) (
    input  logic             clock50,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_sop,
    input  logic             load_eop,
    input  logic             src_ready,
    output logic             src_valid,
    output logic             src_sop,
    output logic             src_eop,
    output logic [WIDTH-1:0] src_data
);

    logic             valid_q;
    logic             sop_q;
    logic             eop_q;
    logic [WIDTH-1:0] data_q;

    // The owner only asserts load when the register is empty or draining this cycle.
    always_ff @(posedge clock50) begin
        if (reset) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            sop_q   <= load_sop;
            eop_q   <= load_eop;
            data_q  <= load_data;
        end else if (src_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign src_valid = valid_q;
    assign src_sop   = sop_q;
    assign src_eop   = eop_q;
    assign src_data  = data_q;

endmodule

// File: rtl/fft_stream_framer.sv
// Frames a sample stream into FFT-core packets of cfg_fftpts beats, zero-padding on flush.
module fft_stream_framer
    import fft_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned PTS_W   = DefPtsW,
    parameter int unsigned MAX_PTS = DefMaxPts,
    parameter int unsigned MIN_PTS = DefMinPts
) (
    input  logic                    clock50,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_real,
    input  logic [DATA_W-1:0]       in_imag,
    input  logic [PTS_W-1:0]        cfg_fftpts,
    input  logic                    cfg_inverse,
    input  logic                    flush,
    output logic                    src_valid,
    input  logic                    src_ready,
    output logic                    src_sop,
    output logic                    src_eop,
    output logic [1:0]              src_error,
    output logic [2*DATA_W+PTS_W:0] src_data,
    output logic                    cfg_err,
    output logic [15:0]             frame_count
);

    localparam int unsigned OutW = 2 * DATA_W + PTS_W + 1;
    localparam logic [PTS_W-1:0] MinPts = PTS_W'(MIN_PTS);
    localparam logic [PTS_W-1:0] MaxPts = PTS_W'(MAX_PTS);
    localparam logic [PTS_W-1:0] OnePt  = PTS_W'(1);

    framer_state_e     state_q, state_d;
    logic [PTS_W-1:0]  idx_q, idx_d;
    logic [PTS_W-1:0]  pts_q, pts_d;
    logic              inv_q, inv_d;
    logic              cfg_err_q;
    logic [15:0]       frame_count_q;

    logic              cfg_ok;
    logic              out_free;
    logic              accept;
    logic              last;
    logic              load;
    logic              beat_sop;
    logic              beat_eop;
    logic [DATA_W-1:0] beat_real;
    logic [DATA_W-1:0] beat_imag;
    logic [PTS_W-1:0]  beat_pts;
    logic              beat_inv;

    assign cfg_ok   = $onehot(cfg_fftpts) && (cfg_fftpts >= MinPts) && (cfg_fftpts <= MaxPts);
    assign out_free = !src_valid || src_ready;
    // Config legality only matters when a new frame would start.
    assign in_ready = (state_q != StPad) && ((state_q != StIdle) || cfg_ok) && out_free;
    assign accept   = in_valid && in_ready;
    assign last     = (idx_q == pts_q - OnePt);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pts_d     = pts_q;
        inv_d     = inv_q;
        load      = 1'b0;
        beat_sop  = 1'b0;
        beat_eop  = 1'b0;
        beat_real = in_real;
        beat_imag = in_imag;
        beat_pts  = pts_q;
        beat_inv  = inv_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    pts_d    = cfg_fftpts;
                    inv_d    = cfg_inverse;
                    beat_pts = cfg_fftpts;
                    beat_inv = cfg_inverse;
                    load     = 1'b1;
                    beat_sop = 1'b1;
                    beat_eop = (cfg_fftpts == OnePt);
                    idx_d    = beat_eop ? '0 : OnePt;
                    state_d  = beat_eop ? StIdle : StStream;
                end
            end
            StStream: begin
                if (accept) begin
                    load     = 1'b1;
                    beat_eop = last;
                    idx_d    = last ? '0 : idx_q + OnePt;
                    if (last) state_d = StIdle;
                end
                // A flush that coincides with the final sample ends the frame normally.
                if (flush && !(accept && last)) state_d = StPad;
            end
            StPad: begin
                if (out_free) begin
                    load      = 1'b1;
                    beat_real = '0;
                    beat_imag = '0;
                    beat_eop  = last;
                    idx_d     = last ? '0 : idx_q + OnePt;
                    if (last) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            pts_q         <= '0;
            inv_q         <= 1'b0;
            cfg_err_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pts_q   <= pts_d;
            inv_q   <= inv_d;
            if (state_q == StIdle && in_valid && !cfg_ok) cfg_err_q <= 1'b1;
            if (src_valid && src_ready && src_eop) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    fft_stream_outreg #(
        .WIDTH(OutW)
    ) u_outreg (
        .clock50  (clock50),
        .reset    (reset),
        .load     (load),
        .load_data({beat_real, beat_imag, beat_pts, beat_inv}),
        .load_sop (beat_sop),
        .load_eop (beat_eop),
        .src_ready(src_ready),
        .src_valid(src_valid),
        .src_sop  (src_sop),
        .src_eop  (src_eop),
        .src_data (src_data)
    );

    assign src_error   = 2'b00;
    assign cfg_err     = cfg_err_q;
    assign frame_count = frame_count_q;

endmodule
